enigma_msg_sequencer: RTL and testbench

- Message-level controller in front of enigma_top.
- On a start command it latches the message length and pulses rotors_rst so the rotors return to their initial positions.
- It then feeds symbols one at a time from an upstream valid/ready source and waits for each coded symbol before accepting the next.
- It reports done or timeout status for the message.

---
 rtl/enigma_msg_sequencer.sv | 102 ++++++++++
 tb/tb_enigma_msg_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/enigma_msg_sequencer.sv
// enigma_msg_sequencer: message-level controller that resets the rotors and feeds enigma_top one symbol at a time
module enigma_msg_sequencer #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        msg_len_i,
  input  logic              in_val_i,
  input  logic signed [6:0] in_symb_i,
  output logic              in_rdy_o,
  output logic              en_rotors_rst_o,
  output logic [7:0]        en_symb_numb_o,
  output logic              en_symb_val_o,
  output logic signed [6:0] en_symbol_o,
  input  logic              en_symb_val_i,
  input  logic signed [6:0] en_symbol_i,
  output logic              out_val_o,
  output logic signed [6:0] out_symb_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_timeout_o
);
  typedef enum logic [2:0] {IDLE, ROT_RST, FEED, WAIT, DONE} state_t;
  localparam logic [3:0] rst_last = 4'(RST_CYCLES);
  localparam logic [7:0] to_last  = 8'(TIMEOUT);
  state_t     state;
  logic [7:0] len_cnt;
  logic [7:0] to_cnt;
  logic [3:0] rst_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      len_cnt         <= '0;
      to_cnt          <= '0;
      rst_cnt         <= '0;
      in_rdy_o        <= 1'b0;
      en_rotors_rst_o <= 1'b0;
      en_symb_numb_o  <= '0;
      en_symb_val_o   <= 1'b0;
      en_symbol_o     <= '0;
      out_val_o       <= 1'b0;
      out_symb_o      <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_timeout_o   <= 1'b0;
    end else begin
      done_o        <= 1'b0;
      out_val_o     <= 1'b0;
      en_symb_val_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          en_symb_numb_o  <= msg_len_i;
          len_cnt         <= msg_len_i;
          err_timeout_o   <= 1'b0;
          busy_o          <= 1'b1;
          rst_cnt         <= '0;
          en_rotors_rst_o <= msg_len_i != 8'd0;
          state           <= msg_len_i == 8'd0 ? DONE : ROT_RST;
        end
        ROT_RST: begin
          rst_cnt <= rst_cnt + 4'd1;
          if (rst_cnt + 4'd1 == rst_last) begin
            en_rotors_rst_o <= 1'b0;
            in_rdy_o        <= 1'b1;
            state           <= FEED;
          end
        end
        FEED: if (in_val_i) begin
          in_rdy_o      <= 1'b0;
          en_symbol_o   <= in_symb_i;
          en_symb_val_o <= 1'b1;
          to_cnt        <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          // a response wins over a timeout reached in the same cycle
          if (en_symb_val_i) begin
            out_symb_o <= en_symbol_i;
            out_val_o  <= 1'b1;
            len_cnt    <= len_cnt - 8'd1;
            in_rdy_o   <= len_cnt != 8'd1;
            state      <= len_cnt == 8'd1 ? DONE : FEED;
          end else begin
            to_cnt <= to_cnt + 8'd1;
            if (to_cnt + 8'd1 == to_last) begin
              err_timeout_o <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_enigma_msg_sequencer.sv
// tb_enigma_msg_sequencer: directed checks of the message sequencer
module tb_enigma_msg_sequencer;
  logic              clk_i = 1'b0;
  logic              rst_i, start_i, in_val_i, en_symb_val_i;
  logic [7:0]        msg_len_i;
  logic signed [6:0] in_symb_i, en_symbol_i;
  logic              in_rdy_o, en_rotors_rst_o, en_symb_val_o, out_val_o, busy_o, done_o, err_timeout_o;
  logic [7:0]        en_symb_numb_o;
  logic signed [6:0] en_symbol_o, out_symb_o;
  logic [28:0]       outs;
  int total = 0;
  int bad = 0;
  always #5 clk_i = ~clk_i;
  assign outs = {in_rdy_o, en_rotors_rst_o, en_symb_numb_o, en_symb_val_o, en_symbol_o,
                 out_val_o, out_symb_o, busy_o, done_o, err_timeout_o};
  enigma_msg_sequencer #(.RST_CYCLES(2), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .msg_len_i(msg_len_i),
    .in_val_i(in_val_i), .in_symb_i(in_symb_i), .in_rdy_o(in_rdy_o),
    .en_rotors_rst_o(en_rotors_rst_o), .en_symb_numb_o(en_symb_numb_o),
    .en_symb_val_o(en_symb_val_o), .en_symbol_o(en_symbol_o),
    .en_symb_val_i(en_symb_val_i), .en_symbol_i(en_symbol_i),
    .out_val_o(out_val_o), .out_symb_o(out_symb_o), .busy_o(busy_o),
    .done_o(done_o), .err_timeout_o(err_timeout_o)
  );
  task automatic step;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask
  task automatic wait_issue(input string name);
    for (int i = 0; i < 20 && !en_symb_val_o; i++) step;
    total++;
    if (en_symb_val_o !== 1'b1) begin bad++; $display("FAIL %s_issue got=%b want=1", name, en_symb_val_o); end
  endtask
  task automatic test_reset;
    rst_i = 1'b1;
    step;
    step;
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
    rst_i = 1'b0;
    step;
  endtask
  task automatic test_message;
    int rcnt = 0, dcnt = 0, cd = 0, idx = 0;
    bit pulse_ok = 1'b1, prev_ov = 1'b0, done_after = 1'b0, busy_low = 1'b0, xfer;
    logic signed [6:0] eng_sym = '0;
    logic signed [6:0] got[$];
    in_val_i = 1'b1; in_symb_i = 7'sd0; msg_len_i = 8'd3; start_i = 1'b1;
    step;
    start_i = 1'b0;
    for (int c = 0; c < 80 && dcnt == 0; c++) begin
      if (en_rotors_rst_o) rcnt++;
      if (out_val_o) begin got.push_back(out_symb_o); if (prev_ov) pulse_ok = 1'b0; end
      prev_ov = out_val_o;
      if (done_o) begin dcnt++; busy_low = !busy_o; done_after = got.size() == 3; end
      en_symb_val_i = 1'b0;
      if (cd > 0) begin cd--; if (cd == 0) begin en_symb_val_i = 1'b1; en_symbol_i = eng_sym; end end
      if (en_symb_val_o) begin cd = 2; eng_sym = en_symbol_o + 7'sd5; end
      xfer = in_rdy_o && in_val_i;
      step;
      if (xfer) begin idx++; in_symb_i = 7'(idx); end
    end
    in_val_i = 1'b0; en_symb_val_i = 1'b0;
    for (int c = 0; c < 3; c++) begin step; if (done_o) dcnt++; end
    total++;
    if (rcnt != 2) begin bad++; $display("FAIL msg_rotors_rst_cycles got=%0d want=2", rcnt); end
    total++;
    if (en_symb_numb_o !== 8'd3) begin bad++; $display("FAIL msg_symb_numb got=%0d want=3", en_symb_numb_o); end
    total++;
    if (got.size() != 3) begin bad++; $display("FAIL msg_out_count got=%0d want=3", got.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++;
      if (got[i] !== 7'(i + 5)) begin bad++; $display("FAIL msg_out_symb[%0d] got=%0d want=%0d", i, got[i], i + 5); end
    end
    total++;
    if (!pulse_ok) begin bad++; $display("FAIL msg_out_single_pulse got=0 want=1"); end
    total++;
    if (dcnt != 1 || !done_after) begin bad++; $display("FAIL msg_done got=%0d/%b want=1/1", dcnt, done_after); end
    total++;
    if (!busy_low || err_timeout_o !== 1'b0) begin bad++; $display("FAIL msg_busy_err got=%b/%b want=1/0", busy_low, err_timeout_o); end
  endtask
  task automatic test_zero_len;
    msg_len_i = 8'd0; start_i = 1'b1;
    step;
    start_i = 1'b0;
    total++;
    if ({busy_o, done_o, en_rotors_rst_o, en_symb_val_o} !== 4'b1000) begin
      bad++; $display("FAIL zero_first got=%b want=1000", {busy_o, done_o, en_rotors_rst_o, en_symb_val_o});
    end
    step;
    total++;
    if ({busy_o, done_o, en_rotors_rst_o, en_symb_val_o} !== 4'b0100) begin
      bad++; $display("FAIL zero_done got=%b want=0100", {busy_o, done_o, en_rotors_rst_o, en_symb_val_o});
    end
    step;
    total++;
    if ({busy_o, done_o, en_symb_numb_o} !== 10'd0) begin bad++; $display("FAIL zero_after got=%b/%b/%0d want=0/0/0", busy_o, done_o, en_symb_numb_o); end
  endtask
  task automatic test_timeout;
    int k = 0;
    in_val_i = 1'b1; in_symb_i = 7'sd4; msg_len_i = 8'd1; start_i = 1'b1;
    step;
    start_i = 1'b0;
    wait_issue("timeout");
    in_val_i = 1'b0;
    while (!err_timeout_o && k < 30) begin step; k++; end
    total++;
    if (k != 16) begin bad++; $display("FAIL timeout_delay got=%0d want=16", k); end
    step;
    total++;
    if ({done_o, busy_o, err_timeout_o} !== 3'b101) begin bad++; $display("FAIL timeout_done got=%b want=101", {done_o, busy_o, err_timeout_o}); end
    msg_len_i = 8'd0; start_i = 1'b1;
    step;
    start_i = 1'b0;
    total++;
    if (err_timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b want=0", err_timeout_o); end
    step;
    step;
  endtask
  task automatic test_late_response;
    in_val_i = 1'b1; in_symb_i = 7'sd10; msg_len_i = 8'd1; start_i = 1'b1;
    step;
    start_i = 1'b0;
    wait_issue("late");
    in_val_i = 1'b0;
    repeat (15) step;
    en_symb_val_i = 1'b1; en_symbol_i = 7'sd33;
    step;
    en_symb_val_i = 1'b0;
    total++;
    if ({out_val_o, out_symb_o, err_timeout_o} !== {1'b1, 7'sd33, 1'b0}) begin
      bad++; $display("FAIL late_accept got=%b/%0d/%b want=1/33/0", out_val_o, out_symb_o, err_timeout_o);
    end
    step;
    total++;
    if ({done_o, err_timeout_o} !== 2'b10) begin bad++; $display("FAIL late_done got=%b want=10", {done_o, err_timeout_o}); end
    step;
  endtask
  task automatic test_back_pressure;
    in_val_i = 1'b0; msg_len_i = 8'd1; start_i = 1'b1;
    step;
    start_i = 1'b0;
    for (int i = 0; i < 10 && !in_rdy_o; i++) step;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({in_rdy_o, en_symb_val_o} !== 2'b10) begin bad++; $display("FAIL bp_hold[%0d] got=%b want=10", i, {in_rdy_o, en_symb_val_o}); end
      step;
    end
    in_val_i = 1'b1; in_symb_i = -7'sd3;
    step;
    in_val_i = 1'b0;
    total++;
    if ({in_rdy_o, en_symb_val_o, en_symbol_o} !== {2'b01, -7'sd3}) begin
      bad++; $display("FAIL bp_issue got=%b/%b/%0d want=0/1/-3", in_rdy_o, en_symb_val_o, en_symbol_o);
    end
    en_symb_val_i = 1'b1; en_symbol_i = 7'sd9;
    step;
    en_symb_val_i = 1'b0;
    total++;
    if ({out_val_o, out_symb_o} !== {1'b1, 7'sd9}) begin bad++; $display("FAIL bp_out got=%b/%0d want=1/9", out_val_o, out_symb_o); end
    step;
    total++;
    if (done_o !== 1'b1) begin bad++; $display("FAIL bp_done got=%b want=1", done_o); end
    step;
  endtask
  task automatic test_abort;
    in_val_i = 1'b1; in_symb_i = 7'sd2; msg_len_i = 8'd2; start_i = 1'b1;
    step;
    start_i = 1'b0;
    wait_issue("abort");
    in_val_i = 1'b0; msg_len_i = 8'd9; start_i = 1'b1;
    step;
    start_i = 1'b0;
    total++;
    if ({en_symb_numb_o, busy_o, en_rotors_rst_o, in_rdy_o} !== {8'd2, 3'b100}) begin
      bad++; $display("FAIL abort_start_ignored got=%0d/%b want=2/100", en_symb_numb_o, {busy_o, en_rotors_rst_o, in_rdy_o});
    end
    rst_i = 1'b1;
    step;
    rst_i = 1'b0;
    total++;
    if (outs !== '0) begin bad++; $display("FAIL abort_reset got=%h want=0", outs); end
    step;
    total++;
    if ({done_o, busy_o} !== 2'b00) begin bad++; $display("FAIL abort_no_done got=%b want=00", {done_o, busy_o}); end
    en_symb_val_i = 1'b1; en_symbol_i = 7'sd5;
    step;
    en_symb_val_i = 1'b0;
    total++;
    if ({out_val_o, busy_o} !== 2'b00) begin bad++; $display("FAIL idle_spurious got=%b want=00", {out_val_o, busy_o}); end
    step;
    total++;
    if (out_val_o !== 1'b0) begin bad++; $display("FAIL idle_spurious_late got=%b want=0", out_val_o); end
  endtask
  initial begin
    rst_i = 1'b1; start_i = 1'b0; msg_len_i = '0; in_val_i = 1'b0; in_symb_i = '0;
    en_symb_val_i = 1'b0; en_symbol_i = '0;
    test_reset;
    test_message;
    test_zero_len;
    test_timeout;
    test_late_response;
    test_back_pressure;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
